blockram_access_ctrl: RTL and testbench

BLOCKRAM_ACCESS_CTRL -- requirements
Module: blockram_access_ctrl

---
 rtl/blockram_access_ctrl_pkg.sv | 17 +
 rtl/single_port_blockram.sv | 34 +++
 rtl/blockram_access_ctrl.sv | 116 +++++++++++
 tb/tb_blockram_access_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blockram_access_ctrl_pkg.sv
// Shared constants, state encoding and FIFO pointer helper for the blockram access controller.
package blockram_access_ctrl_pkg;

    localparam int BYTE_LEN_IN_BITS = 8;
    localparam int RESP_FIFO_DEPTH  = 3;

    typedef enum logic [0:0] {
        StInit = 1'b0,
        StRun  = 1'b1
    } ctrl_state_e;

    // Pointers wrap at RESP_FIFO_DEPTH, which is not a power of two.
    function automatic logic [1:0] fifo_ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'(RESP_FIFO_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/single_port_blockram.sv
// Single-port block RAM with per-byte write enables and a one-cycle registered read.
module single_port_blockram
    import blockram_access_ctrl_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS
) (
    input  logic                                 clk_in,
    input  logic                                 access_en_in,
    input  logic [WRITE_MASK_LEN-1:0]            write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     access_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out
);

    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem [NUM_SET];

    always_ff @(posedge clk_in) begin
        if (access_en_in) begin
            for (int i = 0; i < WRITE_MASK_LEN; i++) begin
                if (write_en_in[i]) begin
                    mem[access_set_addr_in][i*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] <=
                        write_entry_in[i*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
                end
            end
            if (write_en_in == '0) begin
                read_entry_out <= mem[access_set_addr_in];
            end
        end
    end

endmodule

// File: rtl/blockram_access_ctrl.sv
// Clears the blockram after reset, then serves masked writes and reads through a
// 3-entry response FIFO whose credit check never depends on same-cycle inputs.
module blockram_access_ctrl
    import blockram_access_ctrl_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    output logic                                 init_done_out,
    input  logic                                 request_valid_in,
    output logic                                 request_ready_out,
    input  logic [WRITE_MASK_LEN-1:0]            request_write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_data_in,
    output logic                                 response_valid_out,
    input  logic                                 response_ready_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_data_out
);

    ctrl_state_e                          state_q, state_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     sweep_ptr_q, sweep_ptr_d;
    logic                                 inflight_q;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] fifo_mem_q [RESP_FIFO_DEPTH];
    logic [1:0]                           fifo_rd_ptr_q, fifo_wr_ptr_q, fifo_count_q;
    logic [2:0]                           occupancy;
    logic                                 accept, read_accept, fifo_push, fifo_pop;

    logic                                 ram_access_en;
    logic [WRITE_MASK_LEN-1:0]            ram_write_en;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     ram_addr;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_wdata, ram_rdata;

    // A read in flight already owns a FIFO slot, so credit counts it alongside stored entries.
    assign occupancy          = {1'b0, fifo_count_q} + {2'b00, inflight_q};
    assign request_ready_out  = (state_q == StRun) && (occupancy < 3'(RESP_FIFO_DEPTH));
    assign accept             = request_valid_in && request_ready_out;
    assign read_accept        = accept && (request_write_en_in == '0);
    assign fifo_push          = inflight_q;
    assign response_valid_out = (fifo_count_q != 2'd0);
    assign fifo_pop           = response_valid_out && response_ready_in;
    assign response_data_out  = fifo_mem_q[fifo_rd_ptr_q];
    assign init_done_out      = (state_q == StRun);

    always_comb begin
        state_d       = state_q;
        sweep_ptr_d   = sweep_ptr_q;
        ram_access_en = 1'b0;
        ram_write_en  = request_write_en_in;
        ram_addr      = request_addr_in;
        ram_wdata     = request_data_in;
        unique case (state_q)
            StInit: begin
                ram_access_en = 1'b1;
                ram_write_en  = '1;
                ram_addr      = sweep_ptr_q;
                ram_wdata     = '0;
                sweep_ptr_d   = sweep_ptr_q + SET_PTR_WIDTH_IN_BITS'(1);
                if (sweep_ptr_q == SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                ram_access_en = accept;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q       <= StInit;
            sweep_ptr_q   <= '0;
            inflight_q    <= 1'b0;
            fifo_rd_ptr_q <= 2'd0;
            fifo_wr_ptr_q <= 2'd0;
            fifo_count_q  <= 2'd0;
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
            inflight_q  <= read_accept;
            if (fifo_push) begin
                fifo_mem_q[fifo_wr_ptr_q] <= ram_rdata;
                fifo_wr_ptr_q             <= fifo_ptr_inc(fifo_wr_ptr_q);
            end
            if (fifo_pop) begin
                fifo_rd_ptr_q <= fifo_ptr_inc(fifo_rd_ptr_q);
            end
            if (fifo_push && !fifo_pop) begin
                fifo_count_q <= fifo_count_q + 2'd1;
            end else if (!fifo_push && fifo_pop) begin
                fifo_count_q <= fifo_count_q - 2'd1;
            end
        end
    end

    single_port_blockram #(
        .SINGLE_ENTRY_SIZE_IN_BITS(SINGLE_ENTRY_SIZE_IN_BITS),
        .NUM_SET                  (NUM_SET),
        .SET_PTR_WIDTH_IN_BITS    (SET_PTR_WIDTH_IN_BITS),
        .WRITE_MASK_LEN           (WRITE_MASK_LEN)
    ) u_blockram (
        .clk_in            (clk_in),
        .access_en_in      (ram_access_en),
        .write_en_in       (ram_write_en),
        .access_set_addr_in(ram_addr),
        .write_entry_in    (ram_wdata),
        .read_entry_out    (ram_rdata)
    );

endmodule

// File: tb/tb_blockram_access_ctrl.sv
// Directed bench for blockram_access_ctrl: clear sweep, masked writes, read latency,
// backpressure, streaming and mid-sweep reset.
module tb_blockram_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        init_done_out;
    logic        request_valid_in;
    logic        request_ready_out;
    logic [7:0]  request_write_en_in;
    logic [5:0]  request_addr_in;
    logic [63:0] request_data_in;
    logic        response_valid_out;
    logic        response_ready_in;
    logic [63:0] response_data_out;

    logic [63:0] model [64];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    blockram_access_ctrl dut (
        .clk_in             (clk),
        .reset_in           (reset_in),
        .init_done_out      (init_done_out),
        .request_valid_in   (request_valid_in),
        .request_ready_out  (request_ready_out),
        .request_write_en_in(request_write_en_in),
        .request_addr_in    (request_addr_in),
        .request_data_in    (request_data_in),
        .response_valid_out (response_valid_out),
        .response_ready_in  (response_ready_in),
        .response_data_out  (response_data_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = 64'h0;
    endtask

    // Counts cycles from the deassertion cycle (cycle 1) until init_done_out is seen high.
    task automatic wait_init(input string tag);
        int cyc = 1;
        while (!init_done_out && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(tag, 64'(cyc), 64'd65);
    endtask

    task automatic do_write(input int addr, input logic [63:0] data, input logic [7:0] mask);
        int waited = 0;
        while (!request_ready_out && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("wr_ready", 64'(request_ready_out), 64'd1);
        request_valid_in    = 1'b1;
        request_addr_in     = 6'(addr);
        request_data_in     = data;
        request_write_en_in = mask;
        @(posedge clk); #1;
        request_valid_in    = 1'b0;
        request_write_en_in = 8'h00;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) model[addr][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    // Expects an idle FIFO; checks valid is low in N+1 and high with data in N+2.
    task automatic do_read_check(input string tag, input int addr, input logic [63:0] exp);
        int waited = 0;
        response_ready_in = 1'b1;
        while (!request_ready_out && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        request_valid_in    = 1'b1;
        request_addr_in     = 6'(addr);
        request_write_en_in = 8'h00;
        @(posedge clk); #1;
        request_valid_in = 1'b0;
        check({tag, "_lat1_valid"}, 64'(response_valid_out), 64'd0);
        @(posedge clk); #1;
        check({tag, "_lat2_valid"}, 64'(response_valid_out), 64'd1);
        check({tag, "_data"}, response_data_out, exp);
        @(posedge clk); #1;
        check({tag, "_popped"}, 64'(response_valid_out), 64'd0);
    endtask

    task automatic stream_read(input string tag, input int lo, input int hi);
        int   n         = hi - lo + 1;
        int   sent      = 0;
        int   got       = 0;
        int   cyc       = 0;
        int   first_cyc = -1;
        int   sent_cyc  = -1;
        logic accepted;
        response_ready_in = 1'b1;
        while (got < n && cyc < n + 40) begin
            request_valid_in    = (sent < n);
            request_addr_in     = 6'(lo + sent);
            request_write_en_in = 8'h00;
            accepted = request_valid_in && request_ready_out;
            @(posedge clk); #1;
            cyc++;
            if (accepted) begin
                sent++;
                if (sent == n) sent_cyc = cyc;
            end
            if (response_valid_out) begin
                if (first_cyc < 0) first_cyc = cyc;
                check({tag, "_data"}, response_data_out, model[lo + got]);
                check({tag, "_no_bubble"}, 64'(cyc), 64'(first_cyc + got));
                got++;
            end
        end
        request_valid_in = 1'b0;
        check({tag, "_count"}, 64'(got), 64'(n));
        check({tag, "_accept_rate"}, 64'(sent_cyc), 64'(n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic accepted;
        int   next;
        int   got;

        reset_in            = 1'b1;
        request_valid_in    = 1'b0;
        request_write_en_in = 8'h00;
        request_addr_in     = 6'd0;
        request_data_in     = 64'h0;
        response_ready_in   = 1'b1;
        clear_model();

        // Reset state and clear sweep timing
        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done", 64'(init_done_out), 64'd0);
        check("rst_ready", 64'(request_ready_out), 64'd0);
        check("rst_valid", 64'(response_valid_out), 64'd0);
        check("rst_data", response_data_out, 64'h0);
        reset_in = 1'b0;
        check("init_ready_low", 64'(request_ready_out), 64'd0);
        wait_init("init_done_65");
        check("run_ready", 64'(request_ready_out), 64'd1);
        stream_read("all_zero", 0, 63);

        // Write then read the following cycle
        do_write(63, 64'hFFFF_FFFF_0000_0000, 8'hFF);
        do_read_check("wr_rd_63", 63, 64'hFFFF_FFFF_0000_0000);

        // Masked write
        do_write(62, 64'h0, 8'hFF);
        do_write(62, 64'hFFFF_FFFF_FFFF_FFFF, 8'hCC);
        do_read_check("mask_62", 62, 64'hFFFF_0000_FFFF_0000);

        // Backpressure: only three reads fit, drained in order
        for (int i = 1; i <= 5; i++) do_write(i, 64'h0123_4567_89AB_CD00 | 64'(i), 8'hFF);
        response_ready_in = 1'b0;
        next = 1;
        for (int c = 0; c < 8; c++) begin
            request_valid_in    = (next <= 5);
            request_addr_in     = 6'(next);
            request_write_en_in = 8'h00;
            accepted = request_valid_in && request_ready_out;
            @(posedge clk); #1;
            if (accepted) next++;
        end
        check("bp_accepted", 64'(next - 1), 64'd3);
        check("bp_ready_low", 64'(request_ready_out), 64'd0);
        check("bp_valid", 64'(response_valid_out), 64'd1);
        check("bp_head", response_data_out, 64'h0123_4567_89AB_CD01);
        response_ready_in = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 5; c++) begin
            request_valid_in = (next <= 5);
            request_addr_in  = 6'(next);
            accepted = request_valid_in && request_ready_out;
            if (response_valid_out) begin
                check("bp_order", response_data_out, model[1 + got]);
                got++;
            end
            @(posedge clk); #1;
            if (accepted) next++;
        end
        request_valid_in = 1'b0;
        check("bp_drained", 64'(got), 64'd5);

        // Streaming with live data
        stream_read("stream16", 0, 15);

        // Mid-sweep reset with buffered responses
        do_write(40, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        response_ready_in   = 1'b0;
        request_valid_in    = 1'b1;
        request_addr_in     = 6'd40;
        request_write_en_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        request_valid_in = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_valid", 64'(response_valid_out), 64'd1);
        check("pre_reset_data", response_data_out, 64'hDEAD_BEEF_CAFE_F00D);
        reset_in = 1'b1;
        @(posedge clk); #1;
        check("rst2_valid", 64'(response_valid_out), 64'd0);
        check("rst2_init_done", 64'(init_done_out), 64'd0);
        check("rst2_data", response_data_out, 64'h0);
        reset_in = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_sweep_init_low", 64'(init_done_out), 64'd0);
        reset_in = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", 64'(response_valid_out), 64'd0);
        check("mid_rst_init_done", 64'(init_done_out), 64'd0);
        check("mid_rst_ready", 64'(request_ready_out), 64'd0);
        reset_in = 1'b0;
        response_ready_in = 1'b1;
        clear_model();
        wait_init("reinit_done_65");
        stream_read("after_reset", 0, 15);
        do_read_check("cleared_40", 40, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
